// File: rtl/ysyx_bus_pkg.sv
// Shared types and helpers for the core memory-bus arbiter.
package ysyx_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_AR,
      RD_R,
      WR_AWW,
      WR_B
   } bus_state_e;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } bus_owner_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'd0,
      RESP_EXOKAY = 2'd1,
      RESP_SLVERR = 2'd2,
      RESP_DECERR = 2'd3
   } axi_resp_e;

   // Size follows the number of enabled lanes, so lane-shifted strobes map correctly too.
   function automatic logic [2:0] strb_to_size(input logic [7:0] strb);
      logic [3:0] ones;
      ones = 4'd0;
      for (int i = 0; i < 8; i++) begin
         ones = ones + {3'd0, strb[i]};
      end
      case (ones)
         4'd1:    strb_to_size = 3'd0;
         4'd2:    strb_to_size = 3'd1;
         4'd4:    strb_to_size = 3'd2;
         default: strb_to_size = 3'd3;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_bus_arb_rr.sv
// Two-way round-robin picker between fetch and load; remembers who won the last read grant.
module ysyx_bus_arb_rr
   import ysyx_bus_pkg::*;
(
   input  logic clock,
   input  logic reset_n,
   input  logic req_ifu,
   input  logic req_lsu,
   input  logic advance,
   output logic grant_ifu,
   output logic grant_lsu
);

   bus_owner_e last_reg;

   always_comb begin
      grant_ifu = req_ifu & (~req_lsu | (last_reg == OWN_LSU));
      grant_lsu = req_lsu & ~grant_ifu;
   end

   // Starts as LSU so the first contested read goes to the fetch unit.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_reg <= OWN_LSU;
      end else if (advance) begin
         last_reg <= grant_ifu ? OWN_IFU : OWN_LSU;
      end
   end

endmodule

// File: rtl/ysyx_bus_arb.sv
// Shares the core's single AXI4-Lite-style master port between fetch and load/store.
// One transaction in flight; stores win, reads alternate between IFU and LSU.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_bus_arb
   import ysyx_bus_pkg::*;
#(
   parameter int XLEN = `YSYX_XLEN
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            ifu_arvalid,
   input  logic [XLEN-1:0] ifu_araddr,
   output logic            ifu_bus_ready,
   output logic            ifu_rready,
   output logic [XLEN-1:0] ifu_rdata,
   input  logic            flush_pipe,
   input  logic            lsu_arvalid,
   input  logic [XLEN-1:0] lsu_araddr,
   input  logic [7:0]      lsu_rstrb,
   output logic            lsu_rvalid,
   output logic [XLEN-1:0] lsu_rdata,
   input  logic            lsu_awvalid,
   input  logic            lsu_wvalid,
   input  logic [XLEN-1:0] lsu_awaddr,
   input  logic [XLEN-1:0] lsu_wdata,
   input  logic [7:0]      lsu_wstrb,
   output logic            lsu_wready,
   output logic            m_arvalid,
   input  logic            m_arready,
   output logic [XLEN-1:0] m_araddr,
   output logic [2:0]      m_arsize,
   input  logic            m_rvalid,
   output logic            m_rready,
   input  logic [XLEN-1:0] m_rdata,
   input  logic [1:0]      m_rresp,
   output logic            m_awvalid,
   input  logic            m_awready,
   output logic [XLEN-1:0] m_awaddr,
   output logic [2:0]      m_awsize,
   output logic            m_wvalid,
   input  logic            m_wready,
   output logic [XLEN-1:0] m_wdata,
   output logic [7:0]      m_wstrb,
   input  logic            m_bvalid,
   output logic            m_bready,
   input  logic [1:0]      m_bresp,
   output logic            bus_err
);

   localparam logic [2:0] FETCH_SIZE = 3'($clog2(XLEN / 8));

   bus_state_e      state_reg;
   bus_owner_e      owner_reg;
   logic            drop_reg;
   logic            aw_done_reg;
   logic            w_done_reg;
   logic            m_arvalid_reg;
   logic [XLEN-1:0] m_araddr_reg;
   logic [2:0]      m_arsize_reg;
   logic            m_awvalid_reg;
   logic [XLEN-1:0] m_awaddr_reg;
   logic [2:0]      m_awsize_reg;
   logic            m_wvalid_reg;
   logic [XLEN-1:0] m_wdata_reg;
   logic [7:0]      m_wstrb_reg;
   logic [XLEN-1:0] rdata_reg;
   logic            ifu_rready_reg;
   logic            lsu_rvalid_reg;
   logic            lsu_wready_reg;
   logic            bus_err_reg;
   logic            ifu_bus_ready_reg;

   logic store_req;
   logic fetch_req;
   logic grant_ifu;
   logic grant_lsu;
   logic rr_advance;
   logic aw_fire;
   logic w_fire;
   logic ifu_flushing;

   assign store_req    = lsu_awvalid & lsu_wvalid;
   assign fetch_req    = ifu_arvalid & ~flush_pipe;
   assign rr_advance   = (state_reg == IDLE) & ~store_req & (fetch_req | lsu_arvalid);
   assign aw_fire      = m_awvalid_reg & m_awready;
   assign w_fire       = m_wvalid_reg & m_wready;
   assign ifu_flushing = (owner_reg == OWN_IFU) & flush_pipe;

   ysyx_bus_arb_rr u_rr (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_ifu   (fetch_req),
      .req_lsu   (lsu_arvalid),
      .advance   (rr_advance),
      .grant_ifu (grant_ifu),
      .grant_lsu (grant_lsu)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg         <= IDLE;
         owner_reg         <= OWN_LSU;
         drop_reg          <= 1'b0;
         aw_done_reg       <= 1'b0;
         w_done_reg        <= 1'b0;
         m_arvalid_reg     <= 1'b0;
         m_araddr_reg      <= '0;
         m_arsize_reg      <= 3'd0;
         m_awvalid_reg     <= 1'b0;
         m_awaddr_reg      <= '0;
         m_awsize_reg      <= 3'd0;
         m_wvalid_reg      <= 1'b0;
         m_wdata_reg       <= '0;
         m_wstrb_reg       <= 8'd0;
         rdata_reg         <= '0;
         ifu_rready_reg    <= 1'b0;
         lsu_rvalid_reg    <= 1'b0;
         lsu_wready_reg    <= 1'b0;
         bus_err_reg       <= 1'b0;
         ifu_bus_ready_reg <= 1'b0;
      end else begin
         ifu_rready_reg    <= 1'b0;
         lsu_rvalid_reg    <= 1'b0;
         lsu_wready_reg    <= 1'b0;
         bus_err_reg       <= 1'b0;
         ifu_bus_ready_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               drop_reg <= 1'b0;
               if (store_req) begin
                  owner_reg     <= OWN_LSU;
                  m_awvalid_reg <= 1'b1;
                  m_awaddr_reg  <= lsu_awaddr;
                  m_awsize_reg  <= strb_to_size(lsu_wstrb);
                  m_wvalid_reg  <= 1'b1;
                  m_wdata_reg   <= lsu_wdata;
                  m_wstrb_reg   <= lsu_wstrb;
                  aw_done_reg   <= 1'b0;
                  w_done_reg    <= 1'b0;
                  state_reg     <= WR_AWW;
               end else if (grant_ifu) begin
                  owner_reg     <= OWN_IFU;
                  m_arvalid_reg <= 1'b1;
                  m_araddr_reg  <= ifu_araddr;
                  m_arsize_reg  <= FETCH_SIZE;
                  state_reg     <= RD_AR;
               end else if (grant_lsu) begin
                  owner_reg     <= OWN_LSU;
                  m_arvalid_reg <= 1'b1;
                  m_araddr_reg  <= lsu_araddr;
                  m_arsize_reg  <= strb_to_size(lsu_rstrb);
                  state_reg     <= RD_AR;
               end else begin
                  ifu_bus_ready_reg <= 1'b1;
               end
            end
            RD_AR: begin
               if (ifu_flushing) drop_reg <= 1'b1;
               if (m_arready) begin
                  m_arvalid_reg <= 1'b0;
                  state_reg     <= RD_R;
               end
            end
            RD_R: begin
               if (ifu_flushing) drop_reg <= 1'b1;
               // A flushed fetch still drains its beat; only the completion pulse is withheld.
               if (m_rvalid) begin
                  rdata_reg         <= m_rdata;
                  bus_err_reg       <= (m_rresp != RESP_OKAY);
                  ifu_rready_reg    <= (owner_reg == OWN_IFU) & ~drop_reg & ~flush_pipe;
                  lsu_rvalid_reg    <= (owner_reg == OWN_LSU);
                  ifu_bus_ready_reg <= 1'b1;
                  state_reg         <= IDLE;
               end
            end
            WR_AWW: begin
               if (aw_fire) begin
                  m_awvalid_reg <= 1'b0;
                  aw_done_reg   <= 1'b1;
               end
               if (w_fire) begin
                  m_wvalid_reg <= 1'b0;
                  w_done_reg   <= 1'b1;
               end
               if ((aw_done_reg | aw_fire) & (w_done_reg | w_fire)) begin
                  state_reg <= WR_B;
               end
            end
            WR_B: begin
               if (m_bvalid) begin
                  lsu_wready_reg    <= 1'b1;
                  bus_err_reg       <= (m_bresp != RESP_OKAY);
                  ifu_bus_ready_reg <= 1'b1;
                  state_reg         <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign ifu_bus_ready = ifu_bus_ready_reg;
   assign ifu_rready    = ifu_rready_reg;
   assign ifu_rdata     = rdata_reg;
   assign lsu_rvalid    = lsu_rvalid_reg;
   assign lsu_rdata     = rdata_reg;
   assign lsu_wready    = lsu_wready_reg;
   assign m_arvalid     = m_arvalid_reg;
   assign m_araddr      = m_araddr_reg;
   assign m_arsize      = m_arsize_reg;
   assign m_rready      = (state_reg == RD_R);
   assign m_awvalid     = m_awvalid_reg;
   assign m_awaddr      = m_awaddr_reg;
   assign m_awsize      = m_awsize_reg;
   assign m_wvalid      = m_wvalid_reg;
   assign m_wdata       = m_wdata_reg;
   assign m_wstrb       = m_wstrb_reg;
   assign m_bready      = (state_reg == WR_B);
   assign bus_err       = bus_err_reg;

endmodule

// File: tb/tb_ysyx_bus_arb.sv
// Scoreboard bench for ysyx_bus_arb: directed requests against a small AXI-Lite slave model.
module tb_ysyx_bus_arb;

   logic        clock;
   logic        reset_n;
   logic        ifu_arvalid;
   logic [31:0] ifu_araddr;
   logic        ifu_bus_ready;
   logic        ifu_rready;
   logic [31:0] ifu_rdata;
   logic        flush_pipe;
   logic        lsu_arvalid;
   logic [31:0] lsu_araddr;
   logic [7:0]  lsu_rstrb;
   logic        lsu_rvalid;
   logic [31:0] lsu_rdata;
   logic        lsu_awvalid;
   logic        lsu_wvalid;
   logic [31:0] lsu_awaddr;
   logic [31:0] lsu_wdata;
   logic [7:0]  lsu_wstrb;
   logic        lsu_wready;
   logic        m_arvalid;
   logic        m_arready;
   logic [31:0] m_araddr;
   logic [2:0]  m_arsize;
   logic        m_rvalid;
   logic        m_rready;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        m_awvalid;
   logic        m_awready;
   logic [31:0] m_awaddr;
   logic [2:0]  m_awsize;
   logic        m_wvalid;
   logic        m_wready;
   logic [31:0] m_wdata;
   logic [7:0]  m_wstrb;
   logic        m_bvalid;
   logic        m_bready;
   logic [1:0]  m_bresp;
   logic        bus_err;

   ysyx_bus_arb #(.XLEN(32)) dut (
      .clock(clock), .reset_n(reset_n),
      .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_bus_ready(ifu_bus_ready),
      .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .flush_pipe(flush_pipe),
      .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_rstrb(lsu_rstrb),
      .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
      .lsu_awvalid(lsu_awvalid), .lsu_wvalid(lsu_wvalid), .lsu_awaddr(lsu_awaddr),
      .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wready(lsu_wready),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arsize(m_arsize),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awsize(m_awsize),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .bus_err(bus_err)
   );

   typedef struct { logic [31:0] addr; logic [2:0] size; } addr_exp_t;
   typedef struct { logic [31:0] data; logic [7:0] strb; } w_exp_t;
   typedef struct { int kind; logic [31:0] data; logic err; } cmp_exp_t;

   addr_exp_t ar_q[$];
   addr_exp_t aw_q[$];
   w_exp_t    w_q[$];
   cmp_exp_t  cmp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   // Slave configuration and requester stream lengths, set by the directed tests.
   int         r_wait = 0;
   int         b_wait = 0;
   int         aw_wait = 0;
   logic [1:0] r_resp_cfg = 2'd0;
   int         ifu_left = 0;
   int         lsu_left = 0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required completion before it");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   task automatic fail_unexpected(input string name, input logic [63:0] act);
      n_checks++;
      $display("FAIL %s: got event with value %h, required no event", name, act);
   endtask

   task automatic exp_ar(input logic [31:0] a, input logic [2:0] s);
      addr_exp_t e;
      e.addr = a; e.size = s;
      ar_q.push_back(e);
   endtask

   task automatic exp_aw(input logic [31:0] a, input logic [2:0] s);
      addr_exp_t e;
      e.addr = a; e.size = s;
      aw_q.push_back(e);
   endtask

   task automatic exp_w(input logic [31:0] d, input logic [7:0] s);
      w_exp_t e;
      e.data = d; e.strb = s;
      w_q.push_back(e);
   endtask

   // kind: 0 = fetch pulse, 1 = load pulse, 2 = store pulse
   task automatic exp_cmp(input int k, input logic [31:0] d, input logic err);
      cmp_exp_t e;
      e.kind = k; e.data = d; e.err = err;
      cmp_q.push_back(e);
   endtask

   function automatic logic [31:0] slave_mem(input logic [31:0] a);
      return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h5A5A_0000);
   endfunction

   // Slave model plus requesters that release their request on the completion pulse.
   initial begin
      int          r_cnt, b_cnt, aw_cnt;
      logic        r_pend, b_pend, aw_got, w_got;
      logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;
      logic [31:0] r_addr;
      r_cnt = 0; b_cnt = 0; aw_cnt = 0;
      r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; r_addr = 0;
      m_arready = 1; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
      m_awready = 0; m_wready = 1; m_bvalid = 0; m_bresp = 0;
      forever begin
         @(negedge clock);
         ar_hs = m_arvalid & m_arready;
         r_hs  = m_rvalid & m_rready;
         aw_hs = m_awvalid & m_awready;
         w_hs  = m_wvalid & m_wready;
         b_hs  = m_bvalid & m_bready;
         if (ar_hs) r_addr = m_araddr;
         @(posedge clock);
         #1;
         if (!reset_n) begin
            r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; aw_cnt = aw_wait;
            m_rvalid = 0; m_bvalid = 0; m_awready = 0;
         end else begin
            if (r_hs) m_rvalid = 0;
            if (ar_hs) begin r_pend = 1; r_cnt = r_wait; end
            if (r_pend) begin
               if (r_cnt == 0) begin
                  m_rvalid = 1; m_rdata = slave_mem(r_addr); m_rresp = r_resp_cfg; r_pend = 0;
               end else r_cnt--;
            end
            if (b_hs) m_bvalid = 0;
            if (aw_hs) aw_got = 1;
            if (w_hs) w_got = 1;
            if (aw_got && w_got) begin b_pend = 1; b_cnt = b_wait; aw_got = 0; w_got = 0; end
            if (b_pend) begin
               if (b_cnt == 0) begin m_bvalid = 1; m_bresp = 0; b_pend = 0; end
               else b_cnt--;
            end
            if (aw_hs) aw_cnt = aw_wait;
            m_awready = (aw_cnt == 0);
            if (m_awvalid && aw_cnt > 0) aw_cnt--;
            if (ifu_rready) begin
               if (ifu_left > 1) begin ifu_left--; ifu_araddr += 32'd4; end
               else begin ifu_left = 0; ifu_arvalid = 0; end
            end
            if (lsu_rvalid) begin
               if (lsu_left > 1) begin lsu_left--; lsu_araddr += 32'd4; end
               else begin lsu_left = 0; lsu_arvalid = 0; end
            end
            if (lsu_wready) begin lsu_awvalid = 0; lsu_wvalid = 0; end
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT shows a handshake or completion.
   initial begin
      addr_exp_t ea;
      w_exp_t    ew;
      cmp_exp_t  ec;
      int        got_kind;
      forever begin
         @(negedge clock);
         if (reset_n) begin
            if (m_arvalid && m_arready) begin
               if (ar_q.size() == 0) fail_unexpected("ar_handshake", {29'd0, m_arsize, m_araddr});
               else begin
                  ea = ar_q.pop_front();
                  check("ar_addr_size", {m_araddr, m_arsize}, {ea.addr, ea.size});
               end
            end
            if (m_awvalid && m_awready) begin
               if (aw_q.size() == 0) fail_unexpected("aw_handshake", {29'd0, m_awsize, m_awaddr});
               else begin
                  ea = aw_q.pop_front();
                  check("aw_addr_size", {m_awaddr, m_awsize}, {ea.addr, ea.size});
               end
            end
            if (m_wvalid && m_wready) begin
               if (w_q.size() == 0) fail_unexpected("w_handshake", {24'd0, m_wstrb, m_wdata});
               else begin
                  ew = w_q.pop_front();
                  check("w_data_strb", {m_wdata, m_wstrb}, {ew.data, ew.strb});
               end
            end
            if (ifu_rready || lsu_rvalid || lsu_wready) begin
               got_kind = ifu_rready ? 0 : (lsu_rvalid ? 1 : 2);
               if (cmp_q.size() == 0) fail_unexpected("completion", 64'(got_kind));
               else begin
                  ec = cmp_q.pop_front();
                  check("completion_kind", 64'(got_kind), 64'(ec.kind));
                  if (ec.kind != 2) check("completion_data", ifu_rready ? ifu_rdata : lsu_rdata, ec.data);
                  check("completion_bus_err", bus_err, ec.err);
               end
            end else if (bus_err) begin
               fail_unexpected("bus_err_without_completion", 64'(bus_err));
            end
         end
      end
   end

   // Ends on posedge+2, which the tests treat as cycle 0.
   task automatic do_reset();
      reset_n = 0;
      ifu_arvalid = 0; lsu_arvalid = 0; lsu_awvalid = 0; lsu_wvalid = 0; flush_pipe = 0;
      ifu_left = 0; lsu_left = 0;
      ar_q.delete(); aw_q.delete(); w_q.delete(); cmp_q.delete();
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1;
      #1;
      check("bus_ready_at_release", ifu_bus_ready, 0);
      @(posedge clock);
      #2;
      check("bus_ready_after_release", ifu_bus_ready, 1);
   endtask

   task automatic wait_drain(input string name, input int max_cycles);
      logic done;
      done = 0;
      for (int i = 0; i < max_cycles && !done; i++) begin
         @(posedge clock);
         #2;
         done = (ar_q.size() == 0) && (aw_q.size() == 0) && (w_q.size() == 0) && (cmp_q.size() == 0)
                && !ifu_arvalid && !lsu_arvalid && !lsu_awvalid && ifu_bus_ready;
      end
      check(name, done, 1);
   endtask

   initial begin
      logic found;
      ifu_arvalid = 0; ifu_araddr = 0; flush_pipe = 0;
      lsu_arvalid = 0; lsu_araddr = 0; lsu_rstrb = 0;
      lsu_awvalid = 0; lsu_wvalid = 0; lsu_awaddr = 0; lsu_wdata = 0; lsu_wstrb = 0;

      // Single fetch with zero-wait slave
      do_reset();
      exp_ar(32'h8000_0000, 3'd2);
      exp_cmp(0, 32'h0000_0413, 1'b0);
      ifu_araddr = 32'h8000_0000; ifu_left = 1; ifu_arvalid = 1;
      repeat (3) begin @(posedge clock); #2; end
      check("fetch_pulse_cycle3", ifu_rready, 1);
      check("fetch_rdata_cycle3", ifu_rdata, 32'h0000_0413);
      wait_drain("drain_single_fetch", 20);

      // Contested reads from reset: IFU, LSU, IFU, LSU
      do_reset();
      exp_ar(32'h8000_0000, 3'd2); exp_cmp(0, 32'h0000_0413, 1'b0);
      exp_ar(32'h8000_0100, 3'd2); exp_cmp(1, 32'hDA5A_0100, 1'b0);
      exp_ar(32'h8000_0004, 3'd2); exp_cmp(0, 32'hDA5A_0004, 1'b0);
      exp_ar(32'h8000_0104, 3'd2); exp_cmp(1, 32'hDA5A_0104, 1'b0);
      ifu_araddr = 32'h8000_0000; ifu_left = 2; ifu_arvalid = 1;
      lsu_araddr = 32'h8000_0100; lsu_rstrb = 8'h0F; lsu_left = 2; lsu_arvalid = 1;
      wait_drain("drain_contested", 60);

      // Store beats a pending fetch; slave takes W two cycles before AW
      aw_wait = 2;
      do_reset();
      exp_aw(32'h8000_1000, 3'd2);
      exp_w(32'hCAFE_F00D, 8'h0F);
      exp_cmp(2, 32'h0, 1'b0);
      exp_ar(32'h8000_0008, 3'd2);
      exp_cmp(0, 32'hDA5A_0008, 1'b0);
      lsu_awaddr = 32'h8000_1000; lsu_wdata = 32'hCAFE_F00D; lsu_wstrb = 8'h0F;
      lsu_awvalid = 1; lsu_wvalid = 1;
      ifu_araddr = 32'h8000_0008; ifu_left = 1; ifu_arvalid = 1;
      wait_drain("drain_store_first", 40);
      aw_wait = 0;

      // Flush during RD_R with a 3-cycle read stall
      r_wait = 3;
      do_reset();
      exp_ar(32'h8000_000C, 3'd2);
      ifu_araddr = 32'h8000_000C; ifu_left = 1; ifu_arvalid = 1;
      repeat (2) begin @(posedge clock); #2; end
      flush_pipe = 1; ifu_arvalid = 0; ifu_left = 0;
      @(posedge clock); #2;
      flush_pipe = 0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clock);
         found = m_rvalid & m_rready;
      end
      check("flush_read_completes", found, 1);
      @(posedge clock); #2;
      check("flush_bus_ready_after", ifu_bus_ready, 1);
      check("flush_no_ifu_rready", ifu_rready, 0);
      wait_drain("drain_flush", 20);
      r_wait = 0;

      // LSU byte load with SLVERR
      r_resp_cfg = 2'd2;
      do_reset();
      exp_ar(32'h8000_0203, 3'd0);
      exp_cmp(1, 32'hDA5A_0203, 1'b1);
      lsu_araddr = 32'h8000_0203; lsu_rstrb = 8'h01; lsu_left = 1; lsu_arvalid = 1;
      wait_drain("drain_slverr", 20);
      r_resp_cfg = 2'd0;

      // Reset asserted while waiting for the write response
      b_wait = 5;
      do_reset();
      exp_aw(32'h8000_2000, 3'd3);
      exp_w(32'h1234_5678, 8'hFF);
      lsu_awaddr = 32'h8000_2000; lsu_wdata = 32'h1234_5678; lsu_wstrb = 8'hFF;
      lsu_awvalid = 1; lsu_wvalid = 1;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clock);
         found = m_bready;
      end
      check("reached_wr_b", found, 1);
      check("aw_w_consumed", 64'(aw_q.size() + w_q.size()), 0);
      #3;
      reset_n = 0;
      lsu_awvalid = 0; lsu_wvalid = 0;
      #1;
      check("async_reset_outputs",
            {ifu_bus_ready, ifu_rready, lsu_rvalid, lsu_wready, m_arvalid, m_rready, m_awvalid,
             m_wvalid, m_bready, bus_err, |ifu_rdata, |lsu_rdata, |m_araddr, |m_arsize,
             |m_awaddr, |m_awsize, |m_wdata, |m_wstrb}, 0);
      b_wait = 0;
      do_reset();
      wait_drain("drain_after_reset", 10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
